a2d_sequencer: RTL
==================

// Module: a2d_sequencer
// PURPOSE
//  Schedules the shared SPI A2D converter among the four analog sources the
//  platform samples: left load cell, right load cell, steering pot, battery.
//  One conversion per nxt request, channels taken in fixed round-robin order.
//  Each conversion is a two-transaction SPI exchange: channel select, then read.
//  Drives the SPI master (wrt/cmd/done/rd_data) and holds the latest 12-bit
//  results; lft_ld/rght_ld feed steer_en and the balance controller.
// PARAMETERS
//  CH0      3'd0    A2D channel for slot 0 (lft_ld)
//  CH1      3'd4    A2D channel for slot 1 (rght_ld)
//  CH2      3'd5    A2D channel for slot 2 (steer_pot)
//  CH3      3'd6    A2D channel for slot 3 (batt)
//  GAP_CYC  2       idle clocks between select done and read wrt (>=1)
//  TMO_CYC  1024    clocks waiting for done before a timeout abort
// PORTS
//  clk        in   1   system clock; only clock
//  rst        in   1   reset; synchronous, active-high
//  nxt        in   1   request one conversion of the next slot
//  done       in   1   SPI master transaction complete (1-clk pulse)
//  rd_data    in   16  SPI response word; valid when done=1
//  wrt        out  1   start SPI transaction (1-clk pulse)
//  cmd        out  16  SPI command word; valid while wrt=1
//  lft_ld     out  12  latest slot-0 result
//  rght_ld    out  12  latest slot-1 result
//  steer_pot  out  12  latest slot-2 result
//  batt       out  12  latest slot-3 result
//  busy       out  1   conversion in progress (state != IDLE)
//  rnd_done   out  1   1-clk pulse: slot-3 result written (full round done)
//  err        out  1   sticky: done timeout occurred
//  clr_err    in   1   clears err
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state IDLE, slot index 0, gap/timeout counters
//   0; wrt, cmd, all result regs, busy, rnd_done, err = 0. Takes precedence
//   mid-transaction; an open SPI transaction is abandoned, and its done is
//   ignored because done is sampled only in WAIT_SEL/WAIT_RD.
//  All outputs registered. States: IDLE, WAIT_SEL, GAP, WAIT_RD.
//  IDLE: nxt=1 -> next clk wrt=1, cmd={2'b00,CHn,11'h000}, -> WAIT_SEL.
//   nxt while busy is dropped (no queueing).
//  WAIT_SEL: done=1 -> GAP; rd_data discarded. Timeout cnt counts each clk
//   in WAIT_*; reset to 0 on entering a WAIT_* state.
//  GAP: after GAP_CYC clks, wrt=1 with cmd=16'h0000 -> WAIT_RD.
//  WAIT_RD: done=1 -> next clk result reg[slot] <= rd_data[11:0], other
//   regs hold; slot <= (slot+1) mod 4 (3 wraps to 0); if slot was 3,
//   rnd_done=1 that same clk; -> IDLE.
//  Timeout: TMO_CYC clks in a WAIT_* state with no done -> err<=1, -> IDLE;
//   slot not advanced, no result reg written (same slot retried next nxt).
//   done in the timeout clk counts as done (no error).
//  err: set wins over clr_err in the same clk; otherwise clr_err clears it.
//  wrt never asserted for >1 consecutive clk; cmd holds last value otherwise.
//  Latency nxt->result update: 1 + t_sel + GAP_CYC + t_rd + 1 clks minimum.
// TESTING
//  rst then nxt; SPI model done 20 clks after each wrt, rd_data=16'hFABC ->
//   wrt/cmd 16'h0000 select, then 16'h0000 read; lft_ld=12'hABC, others 0.
//  4 nxt pulses, rd_data 12'h111/222/333/444 -> lft/rght/steer/batt updated
//   in order, cmds 16'h0000/2000/2800/3000, rnd_done once; 5th nxt hits CH0.
//  nxt pulsed every clk during a conversion -> exactly one conversion, one
//   select and one read wrt, busy high throughout.
//  Model never returns done -> err=1 after TMO_CYC clks, busy=0, slot same;
//   clr_err -> err=0; next nxt re-issues the same channel cmd.
//  rst asserted in WAIT_RD, late done arrives -> all outputs 0, no reg write.
//  GAP_CYC=2: measure select done -> read wrt spacing = 3 clks exactly.

Source files
------------

// File: rtl/a2d_sequencer.sv
// a2d_sequencer: round-robin scheduler for the shared SPI A2D converter.
// Each nxt request runs one two-transaction conversion (channel select, then
// read) for the next of four slots and stores the 12-bit result.
module a2d_sequencer #(
    parameter logic [2:0] CH0     = 3'd0,   // slot 0: left load cell
    parameter logic [2:0] CH1     = 3'd4,   // slot 1: right load cell
    parameter logic [2:0] CH2     = 3'd5,   // slot 2: steering pot
    parameter logic [2:0] CH3     = 3'd6,   // slot 3: battery
    parameter int         GAP_CYC = 2,      // idle clocks between select done and read wrt
    parameter int         TMO_CYC = 1024    // clocks to wait for done before aborting
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        done,
    input  logic [15:0] rd_data,
    input  logic        clr_err,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        busy,
    output logic        rnd_done,
    output logic        err
);

    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SEL, GAP, WAIT_RD} state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             wrt_q, wrt_d;
    logic [15:0]      cmd_q, cmd_d;
    logic [11:0]      res_q [4];
    logic [11:0]      res_d [4];
    logic             busy_q, busy_d;
    logic             rnd_done_q, rnd_done_d;
    logic             err_q, err_d;

    logic [2:0]       ch_sel;
    logic             gap_hit;
    logic             tmo_hit;
    logic             tmo_abort;

    // Only the low 12 bits of the SPI response carry the conversion result.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:12];

    assign gap_hit = (gap_cnt_q == GAP_LAST);
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    // Map the current slot to its converter channel.
    always_comb begin
        case (slot_q)
            2'd0:    ch_sel = CH0;
            2'd1:    ch_sel = CH1;
            2'd2:    ch_sel = CH2;
            default: ch_sel = CH3;
        endcase
    end

    // State register; synchronous reset abandons any open SPI transaction.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; done wins over a timeout in the same clock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (nxt) state_d = WAIT_SEL;
            WAIT_SEL: if (done) state_d = GAP;
                      else if (tmo_hit) state_d = IDLE;
            GAP:      if (gap_hit) state_d = WAIT_RD;
            WAIT_RD:  if (done || tmo_hit) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output and datapath next values: SPI strobes, counters, results, flags.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        wrt_d      = 1'b0;
        cmd_d      = cmd_q;
        slot_d     = slot_q;
        gap_cnt_d  = gap_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        res_d      = res_q;
        rnd_done_d = 1'b0;
        tmo_abort  = 1'b0;
        case (state_q)
            IDLE: begin
                if (nxt) begin
                    wrt_d     = 1'b1;
                    cmd_d     = {2'b00, ch_sel, 11'h000};
                    tmo_cnt_d = '0;
                end
            end
            WAIT_SEL: begin
                if (done)         gap_cnt_d = '0;
                else if (tmo_hit) tmo_abort = 1'b1;
                else              tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
            GAP: begin
                if (gap_hit) begin
                    wrt_d     = 1'b1;
                    cmd_d     = 16'h0000;
                    tmo_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            WAIT_RD: begin
                if (done) begin
                    res_d[slot_q] = rd_data[11:0];
                    slot_d        = slot_q + 2'd1;
                    rnd_done_d    = (slot_q == 2'd3);
                end else if (tmo_hit) begin
                    tmo_abort = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
        // A timeout in the same clock as clr_err keeps the error visible.
        err_d  = tmo_abort ? 1'b1 : (clr_err ? 1'b0 : err_q);
    end

    // Datapath and output registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= '0;
            gap_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            wrt_q      <= 1'b0;
            cmd_q      <= '0;
            res_q      <= '{default: '0};
            busy_q     <= 1'b0;
            rnd_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            gap_cnt_q  <= gap_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            wrt_q      <= wrt_d;
            cmd_q      <= cmd_d;
            res_q      <= res_d;
            busy_q     <= busy_d;
            rnd_done_q <= rnd_done_d;
            err_q      <= err_d;
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign lft_ld    = res_q[0];
    assign rght_ld   = res_q[1];
    assign steer_pot = res_q[2];
    assign batt      = res_q[3];
    assign busy      = busy_q;
    assign rnd_done  = rnd_done_q;
    assign err       = err_q;

endmodule
